// File: rtl/tamagotchi_fsm.sv
// Virtual-pet core: button debounce, wellness levels with time decay,
// NORMAL/SLEEP/DEAD state machine, LED/7-segment drive and time-base clock.
module tamagotchi_fsm #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned DECAY_SECONDS   = 30,
  parameter int unsigned TEST_SPEEDUP    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_salud,
  input  logic       btn_energia,
  input  logic       btn_hambre,
  input  logic       btn_diversion,
  input  logic       btn_reset,
  input  logic       btn_test,
  input  logic       ledsign,
  output logic [3:0] display_out,
  output logic [6:0] seg_display,
  output logic       clk_out
);

  localparam int unsigned NBTN          = 6;
  localparam int unsigned DB_W          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HALF_NORM     = CLK_FREQ / 2;
  localparam int unsigned HALF_TEST_RAW = CLK_FREQ / (2 * TEST_SPEEDUP);
  localparam int unsigned HALF_TEST     = (HALF_TEST_RAW == 0) ? 1 : HALF_TEST_RAW;
  localparam int unsigned DIV_W         = $clog2(HALF_NORM + 1);
  localparam int unsigned DC_W          = $clog2(DECAY_SECONDS + 1);

  typedef enum logic [1:0] {ST_NORMAL, ST_SLEEP, ST_DEAD} state_e;

  // Button bit order: salud, energia, hambre, diversion, reset, test.
  logic [NBTN-1:0] btn_raw_c;
  assign btn_raw_c = {btn_test, btn_reset, btn_diversion, btn_hambre, btn_energia, btn_salud};

  logic [NBTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, evt_q, evt_d;
  logic [DB_W-1:0] dbc_q [NBTN];
  logic [DB_W-1:0] dbc_d [NBTN];
  logic            ls1_q, ls1_d, ls2_q, ls2_d;

  logic [DIV_W-1:0] div_q, div_d, half_c;
  logic             clk_out_q, clk_out_d, tick_c;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic             decay_q, decay_d, test_q, test_d;
  logic             soft_rst_c, test_evt_c;

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d, pick_c, inc_c, dec_c, disp_q, disp_d;
  logic [2:0] lvl_q [4];
  logic [2:0] lvl_d [4];
  logic [2:0] sel_lvl_c;
  logic [6:0] seg_q, seg_d;

  assign soft_rst_c  = evt_q[4];
  assign test_evt_c  = evt_q[5];
  assign display_out = disp_q;
  assign seg_display = seg_q;
  assign clk_out     = clk_out_q;

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    case (v)
      3'd0:    seg_of = 7'b1000000;
      3'd1:    seg_of = 7'b1111001;
      3'd2:    seg_of = 7'b0100100;
      3'd3:    seg_of = 7'b0110000;
      3'd4:    seg_of = 7'b0011001;
      3'd5:    seg_of = 7'b0010010;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Synchronize buttons and ledsign; a button level flips after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    sync1_d = btn_raw_c;
    sync2_d = sync1_q;
    ls1_d   = ledsign;
    ls2_d   = ls1_q;
    db_d    = db_q;
    evt_d   = '0;
    for (int i = 0; i < NBTN; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i]  = sync2_q[i];
          evt_d[i] = sync2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounce registers; levels start high so a button held through reset must be re-pressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '1;
      evt_q   <= '0;
      ls1_q   <= 1'b0;
      ls2_q   <= 1'b0;
      for (int i = 0; i < NBTN; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      evt_q   <= evt_d;
      ls1_q   <= ls1_d;
      ls2_q   <= ls2_d;
      for (int i = 0; i < NBTN; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  // Time-base divider, test-mode toggle and decay-step counter.
  always_comb begin
    half_c    = test_q ? DIV_W'(HALF_TEST - 1) : DIV_W'(HALF_NORM - 1);
    div_d     = div_q + DIV_W'(1);
    clk_out_d = clk_out_q;
    tick_c    = 1'b0;
    dcnt_d    = dcnt_q;
    decay_d   = 1'b0;
    test_d    = test_q;
    if (div_q >= half_c) begin
      div_d     = '0;
      clk_out_d = ~clk_out_q;
      tick_c    = ~clk_out_q;
    end
    if (soft_rst_c) begin
      dcnt_d = '0;
    end else if (test_evt_c) begin
      test_d = ~test_q;
      dcnt_d = '0;
    end else if (tick_c) begin
      if (dcnt_q == DC_W'(DECAY_SECONDS - 1)) begin
        dcnt_d  = '0;
        decay_d = 1'b1;
      end else begin
        dcnt_d = dcnt_q + DC_W'(1);
      end
    end
  end

  // Pet state, levels and selection; outputs are derived from next-state values.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    lvl_d     = lvl_q;
    pick_c    = '0;
    inc_c     = '0;
    dec_c     = '0;
    sel_lvl_c = '0;
    disp_d    = '0;
    seg_d     = 7'b1111111;
    if      (evt_q[0]) pick_c = 4'b0001;
    else if (evt_q[1]) pick_c = 4'b0010;
    else if (evt_q[2]) pick_c = 4'b0100;
    else if (evt_q[3]) pick_c = 4'b1000;
    if (soft_rst_c) begin
      state_d = ST_NORMAL;
      sel_d   = '0;
      for (int i = 0; i < 4; i++) lvl_d[i] = 3'd3;
    end else if (state_q != ST_DEAD) begin
      if (state_q == ST_NORMAL) begin
        if (pick_c != '0) begin
          if (sel_q == pick_c) inc_c = pick_c;
          else                 sel_d = pick_c;
        end
        if (decay_q) dec_c = 4'b1111;
      end else if (decay_q) begin
        inc_c = 4'b0010;
      end
      for (int i = 0; i < 4; i++) begin
        if (inc_c[i] && !dec_c[i] && lvl_q[i] < 3'd5) lvl_d[i] = lvl_q[i] + 3'd1;
        if (dec_c[i] && !inc_c[i] && lvl_q[i] > 3'd0) lvl_d[i] = lvl_q[i] - 3'd1;
      end
      if (lvl_d[0] == 3'd0)                   state_d = ST_DEAD;
      else if (state_q == ST_NORMAL && ls2_q) state_d = ST_SLEEP;
      else if (state_q == ST_SLEEP && !ls2_q) state_d = ST_NORMAL;
    end
    for (int i = 0; i < 4; i++) begin
      if (sel_d[i]) sel_lvl_c = lvl_d[i];
    end
    if (state_d == ST_DEAD) begin
      disp_d = 4'b1111;
      seg_d  = 7'b0111111;
    end else if (sel_d != '0) begin
      disp_d = sel_d;
      seg_d  = seg_of(sel_lvl_c);
    end
  end

  // Main and time-base state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_NORMAL;
      sel_q     <= '0;
      for (int i = 0; i < 4; i++) lvl_q[i] <= 3'd3;
      disp_q    <= '0;
      seg_q     <= 7'b1111111;
      div_q     <= '0;
      clk_out_q <= 1'b0;
      dcnt_q    <= '0;
      decay_q   <= 1'b0;
      test_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      lvl_q     <= lvl_d;
      disp_q    <= disp_d;
      seg_q     <= seg_d;
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
      dcnt_q    <= dcnt_d;
      decay_q   <= decay_d;
      test_q    <= test_d;
    end
  end

endmodule

// File: tb/tb_tamagotchi_fsm.sv
// Scoreboard bench for tamagotchi_fsm with a shortened time base and debounce.
module tb_tamagotchi_fsm;

  localparam int unsigned CLK_FREQ = 400;
  localparam int unsigned DEB      = 8;
  localparam int unsigned DECAY    = 3;
  localparam int unsigned SPEED    = 10;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] BLANK = 7'b1111111, DASH = 7'b0111111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_salud = 1'b0, btn_energia = 1'b0, btn_hambre = 1'b0, btn_diversion = 1'b0;
  logic btn_reset = 1'b0, btn_test = 1'b0, ledsign = 1'b0;
  logic [3:0] display_out;
  logic [6:0] seg_display;
  logic       clk_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q [$];
  logic [10:0] last_exp = {4'b0000, BLANK};
  logic [10:0] prev_obs = {4'b0000, BLANK};
  int half_cyc;

  always #5 clk = ~clk;

  tamagotchi_fsm #(
    .CLK_FREQ(CLK_FREQ), .DEBOUNCE_CYCLES(DEB), .DECAY_SECONDS(DECAY), .TEST_SPEEDUP(SPEED)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_salud(btn_salud), .btn_energia(btn_energia), .btn_hambre(btn_hambre),
    .btn_diversion(btn_diversion), .btn_reset(btn_reset), .btn_test(btn_test),
    .ledsign(ledsign),
    .display_out(display_out), .seg_display(seg_display), .clk_out(clk_out)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every output change pops the next expected {display, seg} pair.
  always @(negedge clk) begin
    if (reset && ({display_out, seg_display} !== prev_obs)) begin
      prev_obs = {display_out, seg_display};
      if (exp_q.size() == 0) begin
        check_val("unexpected_change", 32'(prev_obs), 32'(last_exp));
      end else begin
        last_exp = exp_q.pop_front();
        check_val("out_change", 32'(prev_obs), 32'(last_exp));
      end
    end
  end

  task automatic push(input logic [3:0] d, input logic [6:0] s);
    exp_q.push_back({d, s});
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_salud     = v;
      1: btn_energia   = v;
      2: btn_hambre    = v;
      3: btn_diversion = v;
      4: btn_reset     = v;
      default: btn_test = v;
    endcase
  endtask

  // Clean press: held 20 cycles, released, then 20 idle cycles.
  task automatic press(input int idx);
    @(posedge clk); #1;
    set_btn(idx, 1'b1);
    repeat (20) @(posedge clk);
    #1 set_btn(idx, 1'b0);
    repeat (20) @(posedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic steady(input string tag, input logic [3:0] d, input logic [6:0] s);
    @(negedge clk);
    check_val(tag, 32'({display_out, seg_display}), 32'({d, s}));
  endtask

  task automatic measure_half(output int cyc);
    logic prev;
    int n;
    n = 0;
    @(negedge clk);
    prev = clk_out;
    while (clk_out == prev && n < 1000) begin @(negedge clk); n++; end
    prev = clk_out;
    n = 0;
    while (clk_out == prev && n < 1000) begin @(negedge clk); n++; end
    cyc = n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check_val("rst_display", 32'(display_out), 32'd0);
    check_val("rst_seg", 32'(seg_display), 32'(BLANK));
    check_val("rst_clk_out", 32'(clk_out), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    steady("post_rst", 4'b0000, BLANK);

    // Select salud, then raise it to saturation.
    push(4'b0001, S3); press(0);
    push(4'b0001, S4); press(0);
    push(4'b0001, S5); press(0);
    press(0);
    drain("drain_salud", 100);
    steady("salud_sat", 4'b0001, S5);

    push(4'b0010, S3); press(1);
    drain("drain_energia", 100);
    steady("energia_sel", 4'b0010, S3);

    push(4'b0000, BLANK); press(4);
    drain("drain_softrst", 100);
    steady("soft_rst", 4'b0000, BLANK);

    // Test mode: three fast decays kill the pet.
    push(4'b0010, S3); press(1);
    push(4'b0010, S2); push(4'b0010, S1); push(4'b1111, DASH);
    press(5);
    measure_half(half_cyc);
    check_val("test_half_period", 32'(half_cyc), 32'(CLK_FREQ / (2 * SPEED)));
    drain("drain_dead", 400);
    steady("dead", 4'b1111, DASH);
    press(0);
    steady("dead_ignores_care", 4'b1111, DASH);

    press(5);
    push(4'b0000, BLANK); press(4);
    drain("drain_revive", 100);
    steady("revived", 4'b0000, BLANK);

    // Sleep: decay raises energia, care presses are ignored.
    push(4'b0010, S3); press(1);
    ledsign = 1'b1;
    push(4'b0010, S4);
    drain("drain_sleep", 2000);
    steady("sleep_energia", 4'b0010, S4);
    press(1);
    press(0);
    steady("sleep_ignores_care", 4'b0010, S4);

    ledsign = 1'b0;
    repeat (10) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      #1 btn_hambre = 1'b1;
      repeat (4) @(posedge clk);
      #1 btn_hambre = 1'b0;
      repeat (4) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    steady("bounce_ignored", 4'b0010, S4);

    push(4'b0100, S3); press(2);
    push(4'b0001, S3); press(0);
    drain("drain_wake", 100);
    steady("awake_salud", 4'b0001, S3);

    measure_half(half_cyc);
    check_val("norm_half_period", 32'(half_cyc), 32'(CLK_FREQ / 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tamagotchi_fsm.md
# tamagotchi_fsm

Core state machine of the virtual pet. It debounces the four care buttons (salud, energia, hambre, diversion) and the reset and test buttons, and keeps four 0–5 wellness levels that decay over time. It also tracks the pet's state (normal, sleeping, dead). The selected level is driven to a one-hot LED bank and a single 7-segment digit, and a divided time-base clock is exported for the rest of the board.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- DEBOUNCE_CYCLES, 500_000: cycles a button must be stable before it is accepted (10 ms).
- DECAY_SECONDS, 30: time-base ticks between decay steps.
- TEST_SPEEDUP, 10: time-base speed multiplier in test mode.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- btn_salud, input, 1: health button, active high.
- btn_energia, input, 1: energy button, active high.
- btn_hambre, input, 1: feed button, active high.
- btn_diversion, input, 1: play button, active high.
- btn_reset, input, 1: soft-reset button, active high, debounced.
- btn_test, input, 1: test-mode toggle button, active high, debounced.
- ledsign, input, 1: sleep sensor; 1 means lights off (pet sleeps). Synchronized with 2 flip-flops, not debounced.
- display_out, output, 4: one-hot selected level. Bit0 salud, bit1 energia, bit2 hambre, bit3 diversion.
- seg_display, output, 7: active-low segments {g,f,e,d,c,b,a}.
- clk_out, output, 1: time-base square wave. 1 Hz normally; TEST_SPEEDUP Hz in test mode.

## Operation
- **Levels:** four 3-bit levels, range 0..5. Reset value 3. Increments saturate at 5; decrements saturate at 0.
- **Debounce:** each button has a 2-FF synchronizer and a counter. The level changes only after DEBOUNCE_CYCLES consecutive equal samples. A press event is one pulse, one cycle wide, on the rising edge of the debounced level. Holding a button produces exactly one event.
- **Selection register:** values NONE or one of the four levels. Reset value NONE.
- **Care button press in NORMAL:**
  - If the pressed button's level is not selected, select it only.
  - If it is already selected, increment that level by 1.
- **Simultaneous care presses:** priority salud > energia > hambre > diversion. Lower-priority events in the same cycle are dropped.
- **States:**
  - NORMAL: care buttons act as above. Every DECAY_SECONDS time-base ticks, all four levels decrement by 1.
  - SLEEP: entered when synchronized ledsign = 1 in NORMAL. Care buttons are ignored. Each decay step increments energia and leaves the other levels unchanged. Returns to NORMAL when ledsign = 0.
  - DEAD: entered from NORMAL or SLEEP when salud reaches 0. All care buttons and ledsign are ignored. Exits only via reset or btn_reset.
- **Decay and increment in the same cycle:** both apply to that level, net change 0.
- **btn_reset event:** synchronous equivalent of reset, except that test mode is preserved. Levels return to 3, selection to NONE, state to NORMAL, and the decay counter is cleared. It has priority over all other events.
- **btn_test event:** toggles test mode. The decay-step counter restarts on each toggle.
- **display_out:** 0000 for NONE; one-hot of the selection otherwise; 1111 in DEAD.
- **seg_display:**
  - Blank (1111111) when NONE; "-" (0111111) in DEAD.
  - Otherwise the selected level: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010.
- **clk_out:** toggles every CLK_FREQ/2 cycles, or every CLK_FREQ/(2·TEST_SPEEDUP) cycles in test mode. One time-base tick per clk_out rising edge.

## Timing
- **While reset = 0:**
  - display_out = 0000, seg_display = 1111111, clk_out = 0.
  - State NORMAL, test mode off.
  - All counters and synchronizers cleared.
- **Press latency:** the event pulse occurs 2 + DEBOUNCE_CYCLES cycles after the raw rising edge. Level, selection and outputs update on the next clock edge, since all outputs are registered.
- **Release:** produces no event. Bounce shorter than DEBOUNCE_CYCLES is ignored.
- **Time base:** the divider counter runs continuously. A decay step fires on the clock after the DECAY_SECONDS-th tick since the last step.
- **State transitions:**
  - NORMAL→SLEEP and SLEEP→NORMAL take effect 3 cycles after the ledsign edge.
  - Entry to DEAD occurs on the same edge at which salud becomes 0.
- **Reset mid-press:** a button still held when reset deasserts must be released and pressed again to generate an event.

## Test plan
- Apply reset pulse, then release → display_out=0000, seg_display=1111111, clk_out=0.
- Hold btn_salud 100 ms, release → display_out=0001, seg_display=0110000 (3). Second 100 ms press → seg_display=0011001 (4). Third press → 0010010 (5). Fourth press → stays 0010010.
- Press btn_energia after salud is selected → display_out=0010, seg_display=0110000. Energia unchanged; salud stays at its value.
- Enter test mode, let 3·DECAY_SECONDS ticks elapse with no presses → all levels at 0, DEAD, display_out=1111, seg_display=0111111. Press btn_salud → no change. Press btn_reset → display_out=0000, levels 3.
- Set ledsign=1 with energia selected at 3, one decay step → SLEEP, energia 4 (0011001), others unchanged. Care presses ignored.
- Raw btn_hambre pulses of 1 ms (< DEBOUNCE_CYCLES) → no event; display_out unchanged.
